alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the team's single-cycle ALU. Adds signed/unsigned compares, shifts, iterative multiply and unsigned divide/remainder, a full flag set, and valid/ready handshakes on both sides. Sits between the register-read stage and writeback of the datapath. Stalls its producer while an iterative operation is in flight.

## Interface
- WIDTH, 32, operand/result width; power of two, at least 4.
- SH_W, $clog2(WIDTH), shift-amount width; derived, do not override.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- opcode  in  4  operation select.
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand or shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- zero_flag  out  1  result == 0.
- carry_flag  out  1  ADD: carry out. SUB: carry out of a + ~b + 1 (1 = no borrow). 0 otherwise.
- ovf_flag  out  1  signed overflow for ADD/SUB. 0 otherwise.
- neg_flag  out  1  result[WIDTH-1].
- err_flag  out  1  illegal opcode or divide by zero.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (two's complement), 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLT (signed, result 1/0), 7 SLTU (unsigned, result 1/0).
  - 8 SLL, 9 SRL, 10 SRA; shift amount is operand_b[SH_W-1:0].
  - 11 MUL (low WIDTH bits of the unsigned product), 12 DIVU (quotient), 13 REMU (remainder).
  - 14–15 illegal: result 0, err_flag 1.
- States:
  - IDLE: in_ready = 1. On in_valid, capture opcode and operands.
    - Single-cycle ops (0–10, illegal, DIVU/REMU with b = 0) go to DONE.
    - MUL and DIVU/REMU with b ≠ 0 go to BUSY with cnt = WIDTH-1.
  - BUSY: one iteration per clock (shift-add multiply; restoring divide). At cnt = 0, perform the final iteration, then go to DONE. Otherwise decrement cnt.
  - DONE: out_valid = 1, with result and flags held stable. On out_ready, go to IDLE.
- Operands are registered on acceptance. Input changes after acceptance have no effect.
- in_valid is ignored outside IDLE; no queuing.
- Divide by zero: DIVU returns all ones, REMU returns operand_a, err_flag = 1. Takes the single-cycle path.
- Flags are computed from the final result written into DONE, never from a previous result.
- Reset values: result 0; out_valid, zero_flag, carry_flag, ovf_flag, neg_flag, err_flag all 0; state IDLE (so in_ready = 1); iteration registers 0.
- Reset mid-operation: the in-flight op is discarded with no output. Operation resumes from IDLE on the first edge after rst_n deasserts.

## Timing
- Acceptance edge E0: the edge where in_valid && in_ready.
- Single-cycle ops: result, flags and out_valid registered at E0; visible in the next cycle (latency 1).
- Iterative ops: iterations occur at E1..E_WIDTH; out_valid rises after E_WIDTH (latency WIDTH+1; 33 for WIDTH = 32).
- in_ready is combinational from state only, with no path from in_valid.
- Handshake completes at an edge where out_valid && out_ready. out_valid drops and in_ready rises in the following cycle.
- Back-to-back rate: one single-cycle op every 2 cycles at best.
- out_ready held low leaves DONE indefinitely with no output change.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0, zero 1, carry 1, ovf 0, out_valid one cycle after acceptance. SUB 0x80000000 − 1 → 0x7FFFFFFF, ovf 1, carry 1, neg 0.
- SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0. SRA 0x80000000 by 4 → 0xF8000000, neg 1. SLL 1 by 35 (amount 3) → 8. Opcode 15 → result 0, err 1.
- MUL 0x00010003 × 5 → 0x0005000F, out_valid exactly 33 cycles after acceptance. in_ready low throughout. An in_valid pulse with different operands during BUSY does not alter the result.
- DIVU 100/7 → 14, REMU 100/7 → 2, both after 33 cycles. DIVU 9/0 → 0xFFFFFFFF, err 1, latency 1. REMU 9/0 → 9, err 1.
- Backpressure: hold out_ready low for 5 cycles after a DIVU completes → result and flags stable, in_ready 0. Release → IDLE next cycle.
- Assert rst_n low at BUSY cycle 10 of a MUL → all outputs 0 and in_ready 1 immediately. After release, ADD 2+3 → 5 with latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU between register-read and writeback.
//
// Single-cycle group (result registered at the acceptance edge):
//   ADD, SUB, AND, OR, NOR, XOR, SLT, SLTU, SLL, SRL, SRA,
//   illegal opcodes, and DIVU/REMU with a zero divisor.
// Iterative group (WIDTH iterations after acceptance):
//   MUL   (shift-add, low WIDTH bits of the unsigned product)
//   DIVU / REMU (restoring unsigned divide)
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     request handshake; in_ready is high only in IDLE
//   opcode, operand_a/b     operation select and operands (captured on accept)
//   out_valid / out_ready   response handshake; result and flags held in DONE
//   result                  WIDTH-bit result
//   zero/carry/ovf/neg/err  flags derived from the result written into DONE
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             neg_flag,
  output logic             err_flag
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOR  = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIVU = 4'd12,
    OP_REMU = 4'd13
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [3:0]        op_q;
  logic [SH_W-1:0]   cnt_q;
  // Iteration registers, shared between multiply and divide:
  //   MUL : x_q = multiplicand (shifts left), y_q = multiplier (shifts right),
  //         acc_q = partial product
  //   DIV : x_q = divisor, y_q = dividend shifting out / quotient shifting in,
  //         acc_q = partial remainder
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-1:0]  acc_q;

  logic [WIDTH-1:0]  result_q;
  logic              out_valid_q;
  logic              zero_q;
  logic              carry_q;
  logic              ovf_q;
  logic              neg_q;
  logic              err_q;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (driven directly from the request inputs in IDLE)
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]    add_d;
  logic [WIDTH:0]    sub_d;
  logic [SH_W-1:0]   sh_amt;
  logic [WIDTH-1:0]  sc_result_d;
  logic              sc_carry_d;
  logic              sc_ovf_d;
  logic              sc_err_d;
  logic              go_busy_d;

  always_comb begin
    add_d       = {1'b0, operand_a} + {1'b0, operand_b};
    // Carry out of a + ~b + 1: 1 means no borrow.
    sub_d       = {1'b0, operand_a} + {1'b0, ~operand_b} + {{WIDTH{1'b0}}, 1'b1};
    sh_amt      = operand_b[SH_W-1:0];
    sc_result_d = '0;
    sc_carry_d  = 1'b0;
    sc_ovf_d    = 1'b0;
    sc_err_d    = 1'b0;

    case (opcode)
      OP_ADD: begin
        sc_result_d = add_d[WIDTH-1:0];
        sc_carry_d  = add_d[WIDTH];
        sc_ovf_d    = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (add_d[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result_d = sub_d[WIDTH-1:0];
        sc_carry_d  = sub_d[WIDTH];
        sc_ovf_d    = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (sub_d[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND:  sc_result_d = operand_a & operand_b;
      OP_OR:   sc_result_d = operand_a | operand_b;
      OP_NOR:  sc_result_d = ~(operand_a | operand_b);
      OP_XOR:  sc_result_d = operand_a ^ operand_b;
      OP_SLT:  sc_result_d = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: sc_result_d = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OP_SLL:  sc_result_d = operand_a << sh_amt;
      OP_SRL:  sc_result_d = operand_a >> sh_amt;
      OP_SRA:  sc_result_d = $signed(operand_a) >>> sh_amt;
      OP_MUL:  sc_result_d = '0;
      // Only reached on the single-cycle path when the divisor is zero.
      OP_DIVU: begin
        sc_result_d = '1;
        sc_err_d    = 1'b1;
      end
      OP_REMU: begin
        sc_result_d = operand_a;
        sc_err_d    = 1'b1;
      end
      default: begin
        sc_result_d = '0;
        sc_err_d    = 1'b1;
      end
    endcase

    go_busy_d = (opcode == OP_MUL) ||
                (((opcode == OP_DIVU) || (opcode == OP_REMU)) && (operand_b != '0));
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath (one step per clock in BUSY)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  mul_acc_d;
  logic [WIDTH:0]    rem_sh_d;
  logic [WIDTH-1:0]  rem_diff_d;
  logic [WIDTH-1:0]  div_rem_d;
  logic [WIDTH-1:0]  div_quo_d;
  logic [WIDTH-1:0]  it_result_d;

  always_comb begin
    mul_acc_d = y_q[0] ? (acc_q + x_q) : acc_q;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The subtraction is done at WIDTH
    // bits: when rem_sh >= divisor the difference is below the divisor.
    rem_sh_d   = {acc_q, y_q[WIDTH-1]};
    rem_diff_d = rem_sh_d[WIDTH-1:0] - x_q;
    if (rem_sh_d >= {1'b0, x_q}) begin
      div_rem_d = rem_diff_d;
      div_quo_d = {y_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_d = rem_sh_d[WIDTH-1:0];
      div_quo_d = {y_q[WIDTH-2:0], 1'b0};
    end

    case (op_q)
      OP_DIVU: it_result_d = div_quo_d;
      OP_REMU: it_result_d = div_rem_d;
      default: it_result_d = mul_acc_d;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= opcode;
            if (go_busy_d) begin
              state_q <= S_BUSY;
              cnt_q   <= SH_W'(WIDTH - 1);
              acc_q   <= '0;
              if (opcode == OP_MUL) begin
                x_q <= operand_a;
                y_q <= operand_b;
              end else begin
                x_q <= operand_b;
                y_q <= operand_a;
              end
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= sc_result_d;
              zero_q      <= (sc_result_d == '0);
              carry_q     <= sc_carry_d;
              ovf_q       <= sc_ovf_d;
              neg_q       <= sc_result_d[WIDTH-1];
              err_q       <= sc_err_d;
            end
          end
        end

        S_BUSY: begin
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_d;
            x_q   <= x_q << 1;
            y_q   <= y_q >> 1;
          end else begin
            acc_q <= div_rem_d;
            y_q   <= div_quo_d;
          end

          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= it_result_d;
            zero_q      <= (it_result_d == '0);
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= it_result_d[WIDTH-1];
            err_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;
  assign neg_flag   = neg_q;
  assign err_flag   = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- scoreboard bench for alu_mc (WIDTH = 32).
// Stimulus pushes the hand-computed expected response (result, flags
// {zero,carry,ovf,neg,err}, latency) into a queue; a monitor pops and compares
// whenever out_valid is first presented.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam logic [3:0] ADD  = 4'd0,  SUB  = 4'd1,  AND_ = 4'd2,  OR_  = 4'd3;
  localparam logic [3:0] NOR_ = 4'd4,  XOR_ = 4'd5,  SLT  = 4'd6,  SLTU = 4'd7;
  localparam logic [3:0] SLL  = 4'd8,  SRL  = 4'd9,  SRA  = 4'd10, MUL  = 4'd11;
  localparam logic [3:0] DIVU = 4'd12, REMU = 4'd13, ILL  = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero_flag, carry_flag, ovf_flag, neg_flag, err_flag;
  logic [4:0]  flags;

  assign flags = {zero_flag, carry_flag, ovf_flag, neg_flag, err_flag};

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .neg_flag   (neg_flag),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare once per presented response.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          fail_now("unexpected out_valid");
        end else begin
          e = sb.pop_front();
          chk({e.name, " result"},  result, e.res);
          chk({e.name, " flags"},   32'(flags), 32'(e.flg));
          chk({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  // Issue one request; the expected response is queued before the accept edge.
  task automatic send(input string name, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [4:0] flg, input int lat);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now({name, " in_ready timeout"});
      return;
    end
    opcode    = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    e.name = name;
    e.res  = res;
    e.flg  = flg;
    e.lat  = lat;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operand_a = 32'hDEADBEEF;
    operand_b = 32'h12345678;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now({name, " response timeout"});
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [4:0] flg, input int lat);
    send(name, op, a, b, res, flg, lat);
    wait_done(name);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int bad_ready;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset result", result, 32'h0);
    chk("reset flags", 32'(flags), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;

    // Single-cycle ops. flags = {zero,carry,ovf,neg,err}
    run("ADD wrap",   ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b11000, 1);
    run("SUB ovf",    SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01100, 1);
    run("SUB borrow", SUB,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 5'b00010, 1);
    run("ADD ovf",    ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00110, 1);
    run("AND",        AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000, 1);
    run("OR",         OR_,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 5'b00010, 1);
    run("NOR",        NOR_, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b00010, 1);
    run("XOR",        XOR_, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 5'b10000, 1);
    run("SLT",        SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000, 1);
    run("SLTU",       SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000, 1);
    run("SRA",        SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 5'b00010, 1);
    run("SRL",        SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000, 1);
    run("SLL by 35",  SLL,  32'h00000001, 32'h00000023, 32'h00000008, 5'b00000, 1);
    run("ILLEGAL",    ILL,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001, 1);

    // MUL with in_ready watch and a stray request during BUSY
    send("MUL", MUL, 32'h00010003, 32'h00000005, 32'h0005000F, 5'b00000, 33);
    bad_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        opcode    = ADD;
        operand_a = 32'h7;
        operand_b = 32'h9;
        in_valid  = 1'b1;
      end else begin
        in_valid  = 1'b0;
      end
      if (in_ready) bad_ready++;
      if (sb.size() == 0) break;
    end
    in_valid = 1'b0;
    chk("MUL in_ready high cycles", 32'(bad_ready), 32'h0);
    wait_done("MUL");

    // Divide / remainder
    run("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14,        5'b00000, 33);
    run("REMU 100/7", REMU, 32'd100, 32'd7, 32'd2,         5'b00000, 33);
    run("DIVU 9/0",   DIVU, 32'd9,   32'd0, 32'hFFFFFFFF,  5'b00011, 1);
    run("REMU 9/0",   REMU, 32'd9,   32'd0, 32'd9,         5'b00001, 1);

    // Backpressure on a DIVU result
    @(negedge clk);
    out_ready = 1'b0;
    send("DIVU bp", DIVU, 32'd50, 32'd5, 32'd10, 5'b00000, 33);
    wait_done("DIVU bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp result", result, 32'd10);
      chk("bp flags", 32'(flags), 32'h0);
      chk("bp out_valid", 32'(out_valid), 32'h1);
      chk("bp in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", 32'(out_valid), 32'h0);
    chk("bp release in_ready", 32'(in_ready), 32'h1);

    // Reset in the middle of a MUL
    send("MUL reset", MUL, 32'h00010003, 32'h00000005, 32'h0005000F, 5'b00000, 33);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-reset result", result, 32'h0);
    chk("mid-reset flags", 32'(flags), 32'h0);
    chk("mid-reset out_valid", 32'(out_valid), 32'h0);
    chk("mid-reset in_ready", 32'(in_ready), 32'h1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run("ADD after reset", ADD, 32'd2, 32'd3, 32'd5, 5'b00000, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
